// File: rtl/powlib_sfifo_occ_pkg.sv
// -----------------------------------------------------------------------------
// powlib_sfifo_occ_pkg
//   Shared definitions for the powlib single-clock occupancy FIFO.
//   - powlib_clogb2 : ceil(log2(value)), at least 1; sizes pointers and counts.
//   - fifo_op_e     : per-cycle array operation, encoded as {push, pop}.
// -----------------------------------------------------------------------------
package powlib_sfifo_occ_pkg;

  // Array operation for one cycle, encoded as {write accept, array pop}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Number of bits needed to hold 0..value-1, with a floor of one bit.
  function automatic int powlib_clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_sfifo_ptr.sv
// -----------------------------------------------------------------------------
// powlib_sfifo_ptr
//   Modulo-D wrapping pointer: counts 0..D-1 and wraps to 0, so D need not be
//   a power of two.
//   Ports:
//     clk    in  clock, rising edge
//     rst    in  asynchronous active-low reset (pointer -> 0)
//     i_clr  in  synchronous clear to 0, wins over i_inc
//     i_inc  in  advance by one
//     o_ptr  out current pointer value, CP bits
// -----------------------------------------------------------------------------
module powlib_sfifo_ptr
  import powlib_sfifo_occ_pkg::*;
#(
  parameter  int D  = 8,
  localparam int CP = powlib_clogb2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CP-1:0] o_ptr
);

  logic [CP-1:0] r_ptr;

  // Pointer register: clear, then wrap from D-1 back to 0 on increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == CP'(D - 1)) ? '0 : r_ptr + CP'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/powlib_sfifo_occ.sv
// -----------------------------------------------------------------------------
// powlib_sfifo_occ
//   Single-clock valid/ready FIFO using all D entries (any D >= 2), with an
//   occupancy count, registered almost-full/almost-empty flags and a
//   synchronous flush.
//   Optional feature macro: POWLIB_SFIFO_OCC_OUTREG_EN
//     undefined : rddata = mem[rdptr] (combinational), write->rdvld latency 1
//     defined   : FWFT output register, rddata/rdvld straight from flops,
//                 write->rdvld latency 2, capacity D+1.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   asynchronous active-low reset
//     clr     in   synchronous flush, active-high, beats both handshakes
//     wrdata  in   write data (W)
//     wrvld   in   write valid
//     wrrdy   out  write ready (array not full)
//     rddata  out  read data, meaningful when rdvld=1
//     rdvld   out  read valid
//     rdrdy   in   read ready
//     count   out  stored entries (CW)
//     afull   out  count >= AF
//     aempty  out  count <= AE
// -----------------------------------------------------------------------------
module powlib_sfifo_occ
  import powlib_sfifo_occ_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int D  = 8,
  parameter  int AF = D - 1,
  parameter  int AE = 1,
`ifdef POWLIB_SFIFO_OCC_OUTREG_EN
  localparam int CW = powlib_clogb2(D + 2),
`else
  localparam int CW = powlib_clogb2(D + 1),
`endif
  localparam int CP = powlib_clogb2(D),
  localparam int AW = powlib_clogb2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic [CW-1:0] count,
  output logic          afull,
  output logic          aempty
);

  logic [W-1:0]  r_mem [D];
  logic [CP-1:0] w_wrptr;
  logic [CP-1:0] w_rdptr;
  logic [AW-1:0] r_acnt;       // entries held in the array
  logic [AW-1:0] w_acnt_nxt;
  logic [CW-1:0] w_cnt_nxt;    // total occupancy next cycle
  logic          r_wrrdy;
  logic          r_afull;
  logic          r_aempty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_pop;        // array entry leaves (to reader or output reg)
  fifo_op_e      w_op;

  // Flush masks both handshakes so nothing is stored or consumed that cycle.
  assign w_wr_acc = wrvld & r_wrrdy & ~clr;

`ifdef POWLIB_SFIFO_OCC_OUTREG_EN
  logic          r_ovld;
  logic [W-1:0]  r_odata;
  logic          w_ovld_nxt;
  logic [CW-1:0] r_cnt;

  assign w_rd_acc = r_ovld & rdrdy & ~clr;
  // Refill the output register when it is empty or draining and data waits.
  assign w_pop    = (~r_ovld | w_rd_acc) & (r_acnt != '0) & ~clr;

  // Next valid state of the output register.
  always_comb begin
    w_ovld_nxt = r_ovld;
    if (clr) begin
      w_ovld_nxt = 1'b0;
    end else if (w_pop) begin
      w_ovld_nxt = 1'b1;
    end else if (w_rd_acc) begin
      w_ovld_nxt = 1'b0;
    end else begin
      w_ovld_nxt = r_ovld;
    end
  end

  assign w_cnt_nxt = CW'(w_acnt_nxt) + CW'(w_ovld_nxt);

  // Output register valid and total occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovld <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_ovld <= w_ovld_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Output data register, loaded from the array head on pop.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_odata <= r_mem[w_rdptr];
    end
  end

  assign rddata = r_odata;
  assign rdvld  = r_ovld;
  assign count  = r_cnt;
`else
  logic r_rdvld;

  assign w_rd_acc  = r_rdvld & rdrdy & ~clr;
  assign w_pop     = w_rd_acc;
  assign w_cnt_nxt = w_acnt_nxt;

  // Read valid mirrors non-zero occupancy, kept as a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdvld <= 1'b0;
    end else begin
      r_rdvld <= (w_acnt_nxt != '0);
    end
  end

  assign rddata = r_mem[w_rdptr];
  assign rdvld  = r_rdvld;
  assign count  = r_acnt;
`endif

  assign w_op = fifo_op_e'({w_wr_acc, w_pop});

  // Array occupancy: +1 on push only, -1 on pop only, flush empties.
  always_comb begin
    w_acnt_nxt = r_acnt;
    if (clr) begin
      w_acnt_nxt = '0;
    end else begin
      case (w_op)
        OP_PUSH: w_acnt_nxt = r_acnt + AW'(1);
        OP_POP:  w_acnt_nxt = r_acnt - AW'(1);
        default: w_acnt_nxt = r_acnt;
      endcase
    end
  end

  // Array count and flags; flags compare next count so they move with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acnt   <= '0;
      r_wrrdy  <= 1'b1;
      r_afull  <= (AF == 0);
      r_aempty <= 1'b1;
    end else begin
      r_acnt   <= w_acnt_nxt;
      r_wrrdy  <= (w_acnt_nxt != AW'(D));
      r_afull  <= (w_cnt_nxt >= CW'(AF));
      r_aempty <= (w_cnt_nxt <= CW'(AE));
    end
  end

  // Storage array, written at the write pointer on accept.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wrptr] <= wrdata;
    end
  end

  powlib_sfifo_ptr #(.D(D)) u_wrptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_wr_acc),
    .o_ptr (w_wrptr)
  );

  powlib_sfifo_ptr #(.D(D)) u_rdptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (clr),
    .i_inc (w_pop),
    .o_ptr (w_rdptr)
  );

  assign wrrdy  = r_wrrdy;
  assign afull  = r_afull;
  assign aempty = r_aempty;

endmodule
